// File: rtl/bin_to_bcd_stream_if.sv
// Request/result handshake bundle for bin_to_bcd_stream.
// The master side drives the request and acknowledge; the converter is the slave.
interface bin_to_bcd_stream_if #(
    parameter int INPUT_WIDTH    = 16,
    parameter int DECIMAL_DIGITS = 5
);
    logic [INPUT_WIDTH-1:0]      i_Binary;
    logic                        i_Start;
    logic                        o_Ready;
    logic                        i_Ack;
    logic [DECIMAL_DIGITS*4-1:0] o_BCD;
    logic                        o_DV;
    logic                        o_Overflow;
    logic [3:0]                  o_Digits;
    logic                        o_Sign;

    modport master (
        output i_Binary, i_Start, i_Ack,
        input  o_Ready, o_BCD, o_DV, o_Overflow, o_Digits, o_Sign
    );

    modport slave (
        input  i_Binary, i_Start, i_Ack,
        output o_Ready, o_BCD, o_DV, o_Overflow, o_Digits, o_Sign
    );
endinterface

// File: rtl/bin_to_bcd_stream.sv
// Sequential double-dabble binary-to-BCD converter: one bit per clock, result held until acknowledged.
// Define BCD_SIGNED_INPUT_EN to treat i_Binary as two's complement (sign reported on o_Sign).
module bin_to_bcd_stream #(
    parameter int INPUT_WIDTH    = 16,
    parameter int DECIMAL_DIGITS = 5
) (
    input logic                i_Clock,
    input logic                i_Rst_n,
    bin_to_bcd_stream_if.slave bus
);
    localparam int BCD_W = DECIMAL_DIGITS * 4;
    localparam int CNT_W = $clog2(INPUT_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(INPUT_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] mag_q, mag_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [3:0]             digits_q, digits_d;

    logic [INPUT_WIDTH-1:0] load_mag;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W-1:0]       bcd_shift;
    logic                   shift_out;
    logic [3:0]             shift_digits;

`ifdef BCD_SIGNED_INPUT_EN
    logic sign_q, sign_d;

    // Two's complement negation also maps the most negative value onto its correct unsigned magnitude.
    assign load_mag = bus.i_Binary[INPUT_WIDTH-1]
                    ? (~bus.i_Binary + {{(INPUT_WIDTH-1){1'b0}}, 1'b1})
                    : bus.i_Binary;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sign_q <= 1'b0;
        end else begin
            sign_q <= sign_d;
        end
    end

    always_comb begin
        sign_d = sign_q;
        if (state_q == IDLE && bus.i_Start) begin
            sign_d = bus.i_Binary[INPUT_WIDTH-1];
        end
    end

    assign bus.o_Sign = sign_q;
`else
    assign load_mag   = bus.i_Binary;
    assign bus.o_Sign = 1'b0;
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= IDLE;
            mag_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            digits_q <= 4'd1;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            digits_q <= digits_d;
        end
    end

    // Add-3 correction on every digit, then the combined {BCD, magnitude} register shifts left by one.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DECIMAL_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] > 4'd4) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[BCD_W-2:0], mag_q[INPUT_WIDTH-1]};
        shift_out = bcd_adj[BCD_W-1];
    end

    always_comb begin
        shift_digits = 4'd1;
        for (int i = 0; i < DECIMAL_DIGITS; i++) begin
            if (bcd_shift[4*i +: 4] != 4'd0) begin
                shift_digits = 4'(i + 1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        digits_d = digits_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_Start) begin
                    state_d = CONVERT;
                    mag_d   = load_mag;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            CONVERT: begin
                bcd_d = bcd_shift;
                mag_d = {mag_q[INPUT_WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                ovf_d = ovf_q | shift_out;
                // The last shift lands in DONE so o_DV rises exactly INPUT_WIDTH edges after acceptance.
                if (cnt_q == LAST_SHIFT) begin
                    state_d  = DONE;
                    digits_d = shift_digits;
                end
            end
            DONE: begin
                if (bus.i_Ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_Ready    = (state_q == IDLE);
    assign bus.o_DV       = (state_q == DONE);
    assign bus.o_BCD      = bcd_q;
    assign bus.o_Overflow = ovf_q;
    assign bus.o_Digits   = digits_q;
endmodule

// File: tb/tb_bin_to_bcd_stream.sv
// Scoreboard bench for bin_to_bcd_stream: random conversions checked against an arithmetic decimal model.
// A second small instance (12-bit, 3 digits) exercises overflow truncation.
module tb_bin_to_bcd_stream;
    localparam int W  = 16;
    localparam int D  = 5;
    localparam int SW = 12;
    localparam int SD = 3;

    typedef struct packed {
        logic [59:0] bcd;
        logic        ovf;
        logic [3:0]  digits;
        logic        sign;
    } exp_t;

    typedef struct {
        exp_t e;
        int   acc;
    } sb_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    sb_t  sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_stream_if #(.INPUT_WIDTH(W), .DECIMAL_DIGITS(D)) bus ();
    bin_to_bcd_stream_if #(.INPUT_WIDTH(SW), .DECIMAL_DIGITS(SD)) sbus ();

    bin_to_bcd_stream #(.INPUT_WIDTH(W), .DECIMAL_DIGITS(D)) dut (
        .i_Clock (clk),
        .i_Rst_n (rst_n),
        .bus     (bus.slave)
    );

    bin_to_bcd_stream #(.INPUT_WIDTH(SW), .DECIMAL_DIGITS(SD)) sdut (
        .i_Clock (clk),
        .i_Rst_n (rst_n),
        .bus     (sbus.slave)
    );

    // Decimal reference: plain integer arithmetic on the magnitude.
    function automatic exp_t model(input longint unsigned raw, input int w, input int nd);
        exp_t              r;
        longint unsigned   mag, lim, rem;
        r        = '0;
        r.digits = 4'd1;
`ifdef BCD_SIGNED_INPUT_EN
        if (raw >= (64'd1 << (w - 1))) begin
            r.sign = 1'b1;
            mag    = (64'd1 << w) - raw;
        end else begin
            mag = raw;
        end
`else
        mag = raw;
`endif
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        r.ovf = (mag >= lim);
        rem   = mag % lim;
        for (int i = 0; i < nd; i++) begin
            r.bcd[4*i +: 4] = 4'(rem % 10);
            if ((rem % 10) != 0) r.digits = 4'(i + 1);
            rem = rem / 10;
        end
        return r;
    endfunction

    task automatic check_output(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_expected(input logic [W-1:0] val);
        sb_t t;
        t.e   = model(val, W, D);
        t.acc = cyc + 1;
        sb.push_back(t);
    endtask

    // Waits for the result while scrambling i_Start/i_Binary/i_Ack, holds DONE, then acknowledges.
    task automatic finish_txn(input int hold);
        int n;
        @(negedge clk);
        bus.i_Start = 1'b0;
        n = 0;
        while (!bus.o_DV && n < 100) begin
            bus.i_Start  = 1'($urandom_range(0, 1));
            bus.i_Binary = W'($urandom);
            bus.i_Ack    = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        bus.i_Ack = 1'b0;
        if (!bus.o_DV) begin
            check_output("dv_timeout", 0, 1);
            sb.delete();
            bus.i_Start = 1'b0;
            return;
        end
        repeat (hold) begin
            bus.i_Start  = 1'b1;
            bus.i_Binary = W'($urandom);
            @(negedge clk);
        end
        bus.i_Ack   = 1'b1;
        bus.i_Start = 1'b0;
        @(negedge clk);
        check_output("ack_dv", bus.o_DV, 0);
        check_output("ack_ready", bus.o_Ready, 1);
        bus.i_Ack = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [W-1:0] val, input int hold);
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.o_Ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_Ready) begin
            check_output("ready_timeout", 0, 1);
            return;
        end
        bus.i_Binary = val;
        bus.i_Start  = 1'b1;
        push_expected(val);
        finish_txn(hold);
    endtask

    task automatic run_small(input logic [SW-1:0] val);
        exp_t e;
        int   acc, n;
        e = model(val, SW, SD);
        @(negedge clk);
        sbus.i_Binary = val;
        sbus.i_Start  = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        sbus.i_Start = 1'b0;
        n = 0;
        while (!sbus.o_DV && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("small_latency", longint'(cyc - acc), SW);
        check_output("small_bcd", sbus.o_BCD, e.bcd[SD*4-1:0]);
        check_output("small_ovf", sbus.o_Overflow, e.ovf);
        check_output("small_digits", sbus.o_Digits, e.digits);
        check_output("small_sign", sbus.o_Sign, e.sign);
        sbus.i_Ack = 1'b1;
        @(negedge clk);
        sbus.i_Ack = 1'b0;
    endtask

    // Monitor: pops one expectation per o_DV rise and checks the held result stays frozen.
    initial begin : monitor
        sb_t                  t;
        logic                 dv_prev = 1'b0;
        logic [D*4-1:0]       h_bcd;
        logic                 h_ovf, h_sign;
        logic [3:0]           h_digits;
        forever begin
            @(negedge clk);
            if (bus.o_DV && !dv_prev) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_dv: got o_DV=1 required no result pending (cycle %0d)", cyc);
                end else begin
                    t = sb.pop_front();
                    check_output("latency", longint'(cyc - t.acc), W);
                    check_output("bcd", bus.o_BCD, t.e.bcd[D*4-1:0]);
                    check_output("overflow", bus.o_Overflow, t.e.ovf);
                    check_output("digits", bus.o_Digits, t.e.digits);
                    check_output("sign", bus.o_Sign, t.e.sign);
                end
                h_bcd    = bus.o_BCD;
                h_ovf    = bus.o_Overflow;
                h_sign   = bus.o_Sign;
                h_digits = bus.o_Digits;
            end else if (bus.o_DV && dv_prev) begin
                check_output("hold_bcd", bus.o_BCD, h_bcd);
                check_output("hold_ovf", bus.o_Overflow, h_ovf);
                check_output("hold_sign", bus.o_Sign, h_sign);
                check_output("hold_digits", bus.o_Digits, h_digits);
                check_output("hold_ready", bus.o_Ready, 0);
            end
            dv_prev = bus.o_DV;
        end
    end

    initial begin : stimulus
        int            seen;
        logic [W-1:0]  v;
        bus.i_Binary  = '0;
        bus.i_Start   = 1'b0;
        bus.i_Ack     = 1'b0;
        sbus.i_Binary = '0;
        sbus.i_Start  = 1'b0;
        sbus.i_Ack    = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_output("rst_ready", bus.o_Ready, 1);
        check_output("rst_dv", bus.o_DV, 0);
        check_output("rst_bcd", bus.o_BCD, 0);
        check_output("rst_digits", bus.o_Digits, 1);
        check_output("rst_ovf", bus.o_Overflow, 0);
        check_output("rst_sign", bus.o_Sign, 0);

        // Start is already high when reset releases, so the very next edge must accept.
        @(negedge clk);
        rst_n        = 1'b1;
        bus.i_Binary = 16'hFFFF;
        bus.i_Start  = 1'b1;
        push_expected(16'hFFFF);
        finish_txn(2);

        apply_stimulus(16'h0000, 1);
        apply_stimulus(16'h8000, 0);
        apply_stimulus(16'h0001, 10);
        apply_stimulus(16'd9999, 0);
        for (int i = 0; i < 30; i++) begin
            v = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 99)) : W'($urandom);
            apply_stimulus(v, $urandom_range(0, 3));
        end

        run_small(12'd1234);
        run_small(12'd999);
        run_small(12'd1000);
        run_small(12'd7);

        // Reset five cycles into a conversion must abort it with no late result.
        @(negedge clk);
        bus.i_Binary = 16'h1234;
        bus.i_Start  = 1'b1;
        @(negedge clk);
        bus.i_Start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("abort_dv", bus.o_DV, 0);
        check_output("abort_bcd", bus.o_BCD, 0);
        check_output("abort_ready", bus.o_Ready, 1);
        check_output("abort_digits", bus.o_Digits, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_DV) seen++;
        end
        check_output("abort_no_dv", seen, 0);

        apply_stimulus(16'd4321, 1);
        check_output("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_stream.md
BIN_TO_BCD_STREAM -- requirements
Module: bin_to_bcd_stream

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 16, binary input width; legal range 4..32.
REQ-002 SHALL have parameter DECIMAL_DIGITS, default 5, number of BCD output digits; legal range 1..15.
REQ-003 SHALL have port i_Clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_Rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_Binary  in  INPUT_WIDTH  value to convert; sampled only on acceptance.
REQ-006 SHALL have port i_Start  in  1  request; accepted on a rising edge where i_Start=1 and o_Ready=1.
REQ-007 SHALL have port o_Ready  out  1  high only in IDLE.
REQ-008 SHALL have port i_Ack  in  1  result consumed; meaningful only while o_DV=1.
REQ-009 SHALL have port o_BCD  out  DECIMAL_DIGITS*4  result; digit 0 (units) in bits [3:0].
REQ-010 SHALL have port o_DV  out  1  result valid; held until acknowledged.
REQ-011 SHALL have port o_Overflow  out  1  magnitude exceeded 10^DECIMAL_DIGITS-1.
REQ-012 SHALL have port o_Digits  out  4  count of significant digits; minimum 1.
REQ-013 SHALL have port o_Sign  out  1  result negative.

Function
REQ-014 SHALL implement FSM states IDLE, CONVERT, DONE; IDLE->CONVERT on acceptance, CONVERT->DONE after INPUT_WIDTH shift cycles, DONE->IDLE on edge with i_Ack=1.
REQ-015 On acceptance, SHALL load magnitude register, clear BCD register, shift counter and overflow flag.
REQ-016 Each CONVERT cycle SHALL add 3 to every digit >4 in parallel, then shift {BCD, magnitude} left by one bit.
REQ-017 A 1 shifted out of the top digit SHALL set overflow (sticky for the conversion); o_BCD then holds magnitude mod 10^DECIMAL_DIGITS.
REQ-018 Latency: o_DV SHALL rise exactly INPUT_WIDTH clock edges after the accepting edge.
REQ-019 In DONE, o_BCD, o_Overflow, o_Digits and o_Sign SHALL remain stable until the edge after i_Ack=1.
REQ-020 o_DV SHALL deassert and o_Ready assert on the edge where i_Ack=1 is sampled in DONE; next acceptance no earlier than the following edge.
REQ-021 i_Start SHALL be ignored outside IDLE; i_Ack SHALL be ignored outside DONE.
REQ-022 o_Digits SHALL equal index of most significant nonzero digit plus 1, or 1 for zero result; registered on entry to DONE.
REQ-023 Outputs SHALL be registered; no combinational path from inputs to o_BCD/o_DV.

Reset
REQ-024 Reset assertion SHALL immediately force state IDLE and clear all registers: o_BCD=0, o_DV=0, o_Overflow=0, o_Sign=0, o_Digits=1, o_Ready=1.
REQ-025 Reset mid-CONVERT or mid-DONE SHALL abort the conversion; no o_DV pulse follows release.
REQ-026 First acceptance SHALL be possible on the first rising edge after reset release.

Configuration
REQ-027 Macro BCD_SIGNED_INPUT_EN defined: i_Binary SHALL be two's complement; magnitude = negation when MSB=1; o_Sign=MSB of accepted value; -2^(INPUT_WIDTH-1) SHALL convert correctly.
REQ-028 Macro undefined: i_Binary SHALL be unsigned; o_Sign tied 0; no negation logic.

Verification
REQ-029 W=16,D=5 unsigned: accept 0xFFFF -> o_DV exactly 16 edges later, o_BCD=0x65535, o_Digits=5, o_Overflow=0.
REQ-030 W=16,D=5: accept 0x0000 -> o_BCD=0x00000, o_Digits=1, o_Overflow=0.
REQ-031 W=12,D=3: accept 1234 -> o_BCD=0x234, o_Overflow=1, o_Digits=3.
REQ-032 BCD_SIGNED_INPUT_EN, W=16,D=5: accept 0x8000 -> o_Sign=1, o_BCD=0x32768; accept 0xFFFF -> o_Sign=1, o_BCD=0x00001, o_Digits=1.
REQ-033 Hold i_Ack=0 for 10 cycles in DONE with i_Start=1 and i_Binary toggling -> outputs unchanged, o_Ready=0; pulse i_Ack -> o_DV=0, o_Ready=1 next edge.
REQ-034 Assert i_Rst_n=0 five cycles into CONVERT -> o_DV=0, o_BCD=0, o_Ready=1 immediately; no o_DV within 40 cycles after release without a new start.
